// File: rtl/mem_arbiter.sv
// mem_arbiter: two-port (fetch / data) arbiter in front of a single
// 1-cycle-latency memory port, with fetch starvation guard and access checks.
package mem_arbiter_pkg;
    typedef enum logic [1:0] {
        WRITE_BYTE = 2'd0,
        WRITE_HALF = 2'd1,
        WRITE_WORD = 2'd2
    } write_width_t;
endpackage

module mem_arbiter
    import mem_arbiter_pkg::*;
#(
    parameter int STARVE_LIMIT = 3,
    parameter int ADDR_BITS    = 10,
    parameter int XLEN         = 32
) (
    input  logic               clock,
    input  logic               reset,
    input  logic               if_req,
    input  logic [XLEN-1:0]    if_addr,
    output logic               if_gnt,
    output logic               if_rvalid,
    output logic               if_err,
    output logic [XLEN-1:0]    if_rdata,
    input  logic               d_req,
    input  logic [XLEN-1:0]    d_addr,
    input  logic               d_wenable,
    input  write_width_t       d_wwidth,
    input  logic [XLEN-1:0]    d_wdata,
    output logic               d_gnt,
    output logic               d_rvalid,
    output logic               d_err,
    output logic [XLEN-1:0]    d_rdata,
    output logic [XLEN-1:0]    mem_addr,
    output write_width_t       mem_wwidth,
    output logic               mem_wenable,
    output logic [XLEN-1:0]    mem_wdata,
    input  logic [XLEN-1:0]    mem_rdata
);
    localparam int CNT_W = (STARVE_LIMIT < 1) ? 1 : $clog2(STARVE_LIMIT + 1);
    localparam logic [CNT_W-1:0] LIMIT = CNT_W'(STARVE_LIMIT);

    typedef enum logic [2:0] {S_IDLE, S_IF, S_D, S_IF_ERR, S_D_ERR} state_t;

    state_t           state_p1;
    state_t           state_next;
    logic [CNT_W-1:0] starve_cnt;
    logic             d_store_p1;
    logic             if_legal;
    logic             d_legal;
    logic             fetch_force;

    // Address must lie inside the backing memory and be aligned to its width.
    function automatic logic access_legal(input logic [XLEN-1:0] addr, input write_width_t width);
        logic ok;
        ok = ((addr >> ADDR_BITS) == '0);
        if (width == WRITE_HALF && addr[0])
            ok = 1'b0;
        if (width == WRITE_WORD && addr[1:0] != 2'b00)
            ok = 1'b0;
        return ok;
    endfunction

    // Saturating increment of the fetch denial counter.
    function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
        return (v >= LIMIT) ? LIMIT : v + 1'b1;
    endfunction

    assign if_legal    = access_legal(if_addr, WRITE_WORD);
    assign d_legal     = access_legal(d_addr, d_wwidth);
    assign fetch_force = if_req && (starve_cnt == LIMIT);

    // Grant selection: data first unless fetch has been starved long enough.
    always_comb begin
        if_gnt = 1'b0;
        d_gnt  = 1'b0;
        if (!reset) begin
            if (d_req && !fetch_force)
                d_gnt = 1'b1;
            else if (if_req)
                if_gnt = 1'b1;
        end
    end

    // Memory port steering from the winner; illegal accesses never write.
    always_comb begin
        mem_addr    = '0;
        mem_wwidth  = WRITE_WORD;
        mem_wenable = 1'b0;
        mem_wdata   = '0;
        if (d_gnt) begin
            mem_addr    = d_addr;
            mem_wwidth  = d_wwidth;
            mem_wdata   = d_wdata;
            mem_wenable = d_wenable && d_legal;
        end else if (if_gnt) begin
            mem_addr    = if_addr;
        end
    end

    // Next pending-response state and response outputs of the current state.
    always_comb begin
        state_next = S_IDLE;
        if (d_gnt)
            state_next = d_legal ? S_D : S_D_ERR;
        else if (if_gnt)
            state_next = if_legal ? S_IF : S_IF_ERR;

        if_rvalid = 1'b0;
        if_err    = 1'b0;
        if_rdata  = '0;
        d_rvalid  = 1'b0;
        d_err     = 1'b0;
        d_rdata   = '0;
        if (!reset) begin
            case (state_p1)
                S_IF: begin
                    if_rvalid = 1'b1;
                    if_rdata  = mem_rdata;
                end
                S_D: begin
                    d_rvalid = 1'b1;
                    d_rdata  = d_store_p1 ? '0 : mem_rdata;
                end
                S_IF_ERR: if_err = 1'b1;
                S_D_ERR:  d_err  = 1'b1;
                default: ;
            endcase
        end
    end

    // Response state and starvation counter.
    always_ff @(posedge clock) begin
        if (reset) begin
            state_p1   <= S_IDLE;
            starve_cnt <= '0;
        end else begin
            state_p1 <= state_next;
            if (!if_req || if_gnt)
                starve_cnt <= '0;
            else if (d_gnt)
                starve_cnt <= sat_inc(starve_cnt);
        end
    end

    // Remember whether the granted data access was a store (stores return 0).
    always_ff @(posedge clock) begin
        if (d_gnt)
            d_store_p1 <= d_wenable;
    end
endmodule
